// File: rtl/octal_request_encoder_if.sv
// Handshake bundle for the octal request encoder: request vector in, code stream out.
interface octal_request_encoder_if;
  logic       req_vld;
  logic       req_rdy;
  logic [7:0] req;
  logic       code_vld;
  logic       code_rdy;
  logic [2:0] code;
  logic       code_last;
  logic       zero_pulse;

  // Encoder side
  modport slave (
    input  req_vld, req, code_rdy,
    output req_rdy, code_vld, code, code_last, zero_pulse
  );

  // Source/sink side
  modport master (
    output req_vld, req, code_rdy,
    input  req_rdy, code_vld, code, code_last, zero_pulse
  );
endinterface

// File: rtl/octal_request_encoder.sv
// Sequential 8-to-3 encoder: latches a multi-hot request word and serialises the
// index of every set bit, one per output handshake, in a fixed priority order.
module octal_request_encoder #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  octal_request_encoder_if.slave    bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic [7:0] pend_reg;
  logic [7:0] pend_next;
  logic       zero_pulse_reg;

  logic [2:0] prio_idx;
  logic [7:0] clear_mask;
  logic       one_left;
  logic       in_drain;
  logic       accept;
  logic       take;

  assign in_drain = (state_reg == DRAIN);
  assign accept   = bus.req_vld && !in_drain;
  assign take     = in_drain && bus.code_rdy;

  // Priority index of the pending bits; the last match in scan order wins.
  always_comb begin
    prio_idx = 3'd0;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (pend_reg[i]) prio_idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_reg[i]) prio_idx = 3'(i);
      end
    end
  end

  // One-hot mask of the bit being serviced this cycle.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_clear
      assign clear_mask[gi] = (prio_idx == 3'(gi));
    end
  endgenerate

  // Exactly one pending bit: clearing the lowest set bit leaves nothing.
  assign one_left = (pend_reg != 8'd0) && ((pend_reg & (pend_reg - 8'd1)) == 8'd0);

  // Output decode depends only on registered state and pend, never on code_rdy/req.
  assign bus.req_rdy    = !in_drain;
  assign bus.code_vld   = in_drain;
  assign bus.code       = in_drain ? prio_idx : 3'd0;
  assign bus.code_last  = in_drain && one_left;
  assign bus.zero_pulse = zero_pulse_reg;

  // Next-state and pending-bit update for accept (IDLE) and handshake (DRAIN).
  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          pend_next = bus.req;
          if (bus.req != 8'd0) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (take) begin
          pend_next = pend_reg & ~clear_mask;
          if (one_left) state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        pend_next  = 8'd0;
      end
    endcase
  end

  // State, pending bits and the zero-vector flag; reset discards any remaining codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pend_reg       <= 8'd0;
      zero_pulse_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pend_reg       <= pend_next;
      zero_pulse_reg <= accept && (bus.req == 8'd0);
    end
  end

endmodule

// File: tb/tb_octal_request_encoder.sv
// Bench for octal_request_encoder: two instances (lowest-first and highest-first)
// share one stimulus stream and are checked every cycle against a queue model.
module tb_octal_request_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_vld = 1'b0;
  logic [7:0] req = 8'd0;
  logic       code_rdy = 1'b0;

  always #5 clk = ~clk;

  octal_request_encoder_if bus0 ();
  octal_request_encoder_if bus1 ();

  assign bus0.req_vld  = req_vld;
  assign bus0.req      = req;
  assign bus0.code_rdy = code_rdy;
  assign bus1.req_vld  = req_vld;
  assign bus1.req      = req;
  assign bus1.code_rdy = code_rdy;

  octal_request_encoder #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  octal_request_encoder #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: remaining codes of the current vector, in emission order.
  int q0[$];
  int q1[$];
  bit zp_m = 1'b0;

  initial begin
    bit hs, acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q0.delete();
        q1.delete();
        zp_m = 1'b0;
      end else begin
        hs   = (q0.size() > 0) && code_rdy;
        acc  = (q0.size() == 0) && req_vld;
        zp_m = acc && (req == 8'd0);
        if (hs) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
        if (acc) begin
          for (int k = 0; k < 8; k++) if (req[k]) q0.push_back(k);
          for (int k = 7; k >= 0; k--) if (req[k]) q1.push_back(k);
        end
      end
    end
  end

  task automatic cmp_dut(input string tag, input logic rdy, input logic vld,
                         input logic [2:0] cd, input logic last, input logic zp,
                         input int sz, input int head, input bit zexp);
    chk({tag, " req_rdy"},    rdy,  (sz == 0));
    chk({tag, " code_vld"},   vld,  (sz > 0));
    chk({tag, " code"},       cd,   (sz > 0) ? head : 0);
    chk({tag, " code_last"},  last, (sz == 1));
    chk({tag, " zero_pulse"}, zp,   zexp);
  endtask

  // Handshake logs and counters used by the directed scenarios.
  int cycle = 0;
  int log0[64];
  int log1[64];
  int hs_cyc0[64];
  int n0 = 0, n1 = 0;
  int zp_cnt0 = 0, zp_cnt1 = 0, vld_cnt = 0, rdy_low_cnt = 0;
  int acc40_cycle = -1;
  bit acc40 = 1'b0;

  // Compare process: every cycle, mid-period, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      cmp_dut("lsb", bus0.req_rdy, bus0.code_vld, bus0.code, bus0.code_last, bus0.zero_pulse,
              q0.size(), (q0.size() > 0) ? q0[0] : 0, zp_m);
      cmp_dut("msb", bus1.req_rdy, bus1.code_vld, bus1.code, bus1.code_last, bus1.zero_pulse,
              q1.size(), (q1.size() > 0) ? q1[0] : 0, zp_m);
      if (rst_n) begin
        if (bus0.code_vld && code_rdy) begin
          if (n0 < 64) begin
            log0[n0]    = int'(bus0.code) + 8 * int'(bus0.code_last);
            hs_cyc0[n0] = cycle;
          end
          n0++;
        end
        if (bus1.code_vld && code_rdy) begin
          if (n1 < 64) log1[n1] = int'(bus1.code) + 8 * int'(bus1.code_last);
          n1++;
        end
        if (req_vld && bus0.req_rdy && req == 8'h40) begin
          acc40       = 1'b1;
          acc40_cycle = cycle;
        end
        if (bus0.zero_pulse) zp_cnt0++;
        if (bus1.zero_pulse) zp_cnt1++;
        if (bus0.code_vld || bus1.code_vld) vld_cnt++;
        if (!bus0.req_rdy || !bus1.req_rdy) rdy_low_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    n0 = 0; n1 = 0; zp_cnt0 = 0; zp_cnt1 = 0; vld_cnt = 0; rdy_low_cnt = 0;
    acc40 = 1'b0; acc40_cycle = -1;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (!bus0.req_rdy && k < 50) begin
      cyc();
      k++;
    end
    chk({name, " drain timeout"}, (k < 50), 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " lsb req_rdy"},    bus0.req_rdy,    1);
    chk({name, " lsb code_vld"},   bus0.code_vld,   0);
    chk({name, " lsb code"},       bus0.code,       0);
    chk({name, " lsb code_last"},  bus0.code_last,  0);
    chk({name, " lsb zero_pulse"}, bus0.zero_pulse, 0);
    chk({name, " msb req_rdy"},    bus1.req_rdy,    1);
    chk({name, " msb code_vld"},   bus1.code_vld,   0);
    chk({name, " msb code"},       bus1.code,       0);
  endtask

  // Watchdog: a hung run still reports.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Lowest-first drain of 1010_0110 with the sink always ready
    begin
      int e0[4] = '{1, 2, 5, 15};
      int e1[4] = '{7, 5, 2, 9};
      clear_logs();
      req = 8'hA6; req_vld = 1'b1; code_rdy = 1'b1;
      cyc();
      req_vld = 1'b0;
      wait_idle("a6");
      cyc();
      chk("a6 lsb count", n0, 4);
      chk("a6 msb count", n1, 4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("a6 lsb log[%0d]", i), log0[i], e0[i]);
        chk($sformatf("a6 msb log[%0d]", i), log1[i], e1[i]);
      end
      chk("a6 back-to-back", hs_cyc0[3] - hs_cyc0[0], 3);
    end

    // Full vector with code_rdy toggling
    begin
      int e1[8] = '{7, 6, 5, 4, 3, 2, 1, 8};
      int k = 0;
      clear_logs();
      req = 8'hFF; req_vld = 1'b1; code_rdy = 1'b1;
      cyc();
      req_vld = 1'b0;
      while (!bus0.req_rdy && k < 100) begin
        code_rdy = ~code_rdy;
        cyc();
        k++;
      end
      chk("ff drain timeout", (k < 100), 1);
      code_rdy = 1'b1;
      cyc();
      chk("ff msb count", n1, 8);
      chk("ff lsb count", n0, 8);
      for (int i = 0; i < 8; i++) chk($sformatf("ff msb log[%0d]", i), log1[i], e1[i]);
      chk("ff lsb last", log0[7], 15);
    end

    // Back-to-back zero vectors
    clear_logs();
    req = 8'h00; req_vld = 1'b1;
    cyc();
    cyc();
    req_vld = 1'b0;
    cyc();
    cyc();
    chk("zero lsb pulses", zp_cnt0, 2);
    chk("zero msb pulses", zp_cnt1, 2);
    chk("zero code_vld cycles", vld_cnt, 0);
    chk("zero req_rdy low cycles", rdy_low_cnt, 0);

    // Reset in the middle of a drain
    clear_logs();
    req = 8'h81; req_vld = 1'b1; code_rdy = 1'b1;
    cyc();
    req_vld = 1'b0;
    cyc();
    code_rdy = 1'b0;
    cyc();
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    code_rdy = 1'b1; req = 8'h10; req_vld = 1'b1;
    cyc();
    req_vld = 1'b0;
    wait_idle("midrst");
    cyc();
    chk("midrst lsb count", n0, 2);
    chk("midrst lsb log[0]", log0[0], 0);
    chk("midrst lsb log[1]", log0[1], 12);
    chk("midrst msb count", n1, 2);
    chk("midrst msb log[0]", log1[0], 7);
    chk("midrst msb log[1]", log1[1], 12);

    // Second vector held off during a drain
    begin
      int k = 0;
      clear_logs();
      req = 8'h03; req_vld = 1'b1; code_rdy = 1'b1;
      cyc();
      req = 8'h40;
      while (!acc40 && k < 20) begin
        cyc();
        k++;
      end
      chk("hold accept timeout", (k < 20), 1);
      req_vld = 1'b0;
      wait_idle("hold");
      cyc();
      chk("hold lsb count", n0, 3);
      chk("hold lsb log[0]", log0[0], 0);
      chk("hold lsb log[1]", log0[1], 9);
      chk("hold lsb log[2]", log0[2], 14);
      chk("hold msb log[1]", log1[1], 8);
      chk("hold accept gap", acc40_cycle - hs_cyc0[1], 1);
    end

    // Randomised traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      req = 8'h00;
      else if (sel == 1) req = 8'h01 << $urandom_range(0, 7);
      else if (sel == 2) req = 8'hFF;
      else               req = 8'($urandom);
      req_vld  = ($urandom_range(0, 1) == 1);
      code_rdy = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst_n = 1'b1;
    req_vld = 1'b0;
    code_rdy = 1'b1;
    repeat (12) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
